// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus: request/address from the fetch unit,
// ready/read-data back from instruction memory.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches one word per
// REQ/ISSUE round trip and selects the next PC from jump/branch controls.
// Optional fetch timeout: define IMEM_TIMEOUT_EN to enable the wait
// counter and the sticky fetch_err flag (tied low otherwise).
//
//   state | meaning
//   IDLE  | just out of reset, moves to REQ next cycle
//   REQ   | imem_req high at addr=pc, waiting for imem_ready
//   ISSUE | instr valid for the decoder, held while stall=1
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0040_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        zero,
  input  logic [15:0] imm,
  input  logic [25:0] jump_target,
  fetch_unit_if.master imem,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, ISSUE} state_t;

  state_t      state, state_nxt;
  logic        req_int;
  logic        capture;
  logic        advance;
  logic        br_taken;
  logic [31:0] br_offset;
  logic [31:0] next_pc;

  assign imem.req  = req_int;
  assign imem.addr = pc;
  assign opcode    = instr[31:26];
  assign pc_plus4  = pc + 32'd4;

  // Illegal beq+bne combination falls through as not taken.
  assign br_taken  = (branch_eq && zero && !branch_ne) ||
                     (branch_ne && !zero && !branch_eq);
  assign br_offset = {{14{imm[15]}}, imm, 2'b00};

  // Next-PC select: jump over branch over sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = {pc_plus4[31:28], jump_target, 2'b00};
    else if (br_taken)
      next_pc = pc_plus4 + br_offset;
  end

  // FSM state register; reset forces IDLE so imem_req drops at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    state_nxt   = state;
    req_int     = 1'b0;
    instr_valid = 1'b0;
    capture     = 1'b0;
    advance     = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        req_int = 1'b1;
        if (imem.ready) begin
          capture   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (!stall) begin
          advance   = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // PC and instruction registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= PC_RESET;
      instr <= 32'h0;
    end else begin
      if (capture) instr <= imem.rdata;
      if (advance) pc    <= next_pc;
    end
  end

`ifdef IMEM_TIMEOUT_EN
  localparam int            CW        = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(MAX_WAIT - 1);

  logic [CW-1:0] wait_cnt;
  logic          enter_req;

  assign enter_req = (state_nxt == REQ) && (state != REQ);

  // Wait timer: down-counts REQ cycles without ready; terminal count
  // raises the sticky error and rearms while the same pc is re-requested.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= WAIT_LOAD;
      fetch_err <= 1'b0;
    end else if (enter_req) begin
      wait_cnt <= WAIT_LOAD;
    end else if ((state == REQ) && !imem.ready) begin
      if (wait_cnt == '0) begin
        fetch_err <= 1'b1;
        wait_cnt  <= WAIT_LOAD;
      end else begin
        wait_cnt <= wait_cnt - 1'b1;
      end
    end
  end
`else
  logic unused_max_wait;

  assign unused_max_wait = (MAX_WAIT != 0);
  assign fetch_err       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table of fetch/next-PC cases
// plus hand sequences for reset abort, timeout and address wrap.
module tb_fetch_unit;

`ifdef IMEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n, rst2_n;
  logic        stall, jump, branch_eq, branch_ne, zero;
  logic [15:0] imm;
  logic [25:0] jump_target;
  logic [31:0] instr, pc, pc_plus4;
  logic [5:0]  opcode;
  logic        instr_valid, fetch_err;

  logic [31:0] instr2, pc2, pc_plus4_2;
  logic [5:0]  opcode2;
  logic        instr_valid2, fetch_err2;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit_if imem ();
  fetch_unit_if imem2 ();

  fetch_unit dut (
    .clk(clk), .reset(rst_n), .stall(stall), .jump(jump),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .zero(zero),
    .imm(imm), .jump_target(jump_target), .imem(imem),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  // Second instance starting near the top of the address space.
  fetch_unit #(.PC_RESET(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(rst2_n), .stall(1'b0), .jump(1'b0),
    .branch_eq(1'b0), .branch_ne(1'b0), .zero(1'b0),
    .imm(16'h0), .jump_target(26'h0), .imem(imem2),
    .instr(instr2), .opcode(opcode2), .instr_valid(instr_valid2),
    .pc(pc2), .pc_plus4(pc_plus4_2), .fetch_err(fetch_err2)
  );

  assign imem2.ready = 1'b1;
  assign imem2.rdata = 32'h2400_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          wait_n;
    int          stall_n;
    logic [31:0] rdata;
    logic        j, beq, bne, z;
    logic [15:0] imm;
    logic [25:0] jt;
    logic [31:0] addr;
    logic [31:0] next;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] prev_instr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int guard;
    guard = 0;
    while (!imem.req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("req_seen", {31'h0, imem.req}, 32'd1);
    chk("fetch_addr", imem.addr, v.addr);
    chk("valid_in_req", {31'h0, instr_valid}, 32'd0);
    imem.ready = 1'b0;
    imem.rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < v.wait_n; i++) begin
      @(negedge clk);
      chk("req_held", {31'h0, imem.req}, 32'd1);
      chk("addr_held", imem.addr, v.addr);
      chk("instr_no_capture", instr, prev_instr);
    end
    imem.ready  = 1'b1;
    imem.rdata  = v.rdata;
    jump        = v.j;
    branch_eq   = v.beq;
    branch_ne   = v.bne;
    zero        = v.z;
    imm         = v.imm;
    jump_target = v.jt;
    @(negedge clk);
    imem.rdata = 32'hBAD0_0000;
    chk("issue_valid", {31'h0, instr_valid}, 32'd1);
    chk("issue_instr", instr, v.rdata);
    chk("issue_opcode", {26'h0, opcode}, {26'h0, v.rdata[31:26]});
    chk("issue_pc", pc, v.addr);
    chk("issue_pc_plus4", pc_plus4, v.addr + 32'd4);
    chk("issue_req_low", {31'h0, imem.req}, 32'd0);
    for (int i = 0; i < v.stall_n; i++) begin
      stall = 1'b1;
      @(negedge clk);
      chk("stall_valid", {31'h0, instr_valid}, 32'd1);
      chk("stall_pc", pc, v.addr);
      chk("stall_instr", instr, v.rdata);
    end
    stall = 1'b0;
    @(negedge clk);
    imem.ready = 1'b0;
    chk("next_req", {31'h0, imem.req}, 32'd1);
    chk("next_addr", imem.addr, v.next);
    chk("valid_dropped", {31'h0, instr_valid}, 32'd0);
    jump = 1'b0; branch_eq = 1'b0; branch_ne = 1'b0; zero = 1'b0;
    imm = 16'h0; jump_target = 26'h0;
    prev_instr = v.rdata;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              wait stall rdata         j  beq bne z  imm       jt            addr          next
    vecs[0]  = '{0, 0, 32'h2001_0001, 0, 0, 0, 0, 16'h0000, 26'h0000000, 32'h0040_0000, 32'h0040_0004};
    vecs[1]  = '{0, 0, 32'h8C22_0004, 0, 0, 0, 0, 16'h0000, 26'h0000000, 32'h0040_0004, 32'h0040_0008};
    vecs[2]  = '{0, 0, 32'hAC23_0008, 0, 0, 0, 0, 16'h0000, 26'h0000000, 32'h0040_0008, 32'h0040_000C};
    vecs[3]  = '{1, 0, 32'h0000_0020, 0, 0, 0, 0, 16'h0000, 26'h0000000, 32'h0040_000C, 32'h0040_0010};
    vecs[4]  = '{0, 0, 32'h1000_FFFC, 0, 1, 0, 1, 16'hFFFC, 26'h0000000, 32'h0040_0010, 32'h0040_0004};
    vecs[5]  = '{0, 0, 32'h0810_0004, 1, 0, 0, 0, 16'h0000, 26'h0100004, 32'h0040_0004, 32'h0040_0010};
    vecs[6]  = '{0, 0, 32'h1000_FFFC, 0, 1, 0, 0, 16'hFFFC, 26'h0000000, 32'h0040_0010, 32'h0040_0014};
    vecs[7]  = '{0, 0, 32'h0810_0004, 1, 0, 0, 0, 16'h0000, 26'h0100004, 32'h0040_0014, 32'h0040_0010};
    vecs[8]  = '{0, 0, 32'h1400_0003, 0, 0, 1, 0, 16'h0003, 26'h0000000, 32'h0040_0010, 32'h0040_0020};
    vecs[9]  = '{0, 1, 32'h0810_0010, 1, 1, 0, 1, 16'h0005, 26'h0100010, 32'h0040_0020, 32'h0040_0040};
    vecs[10] = '{2, 0, 32'h1800_0007, 0, 1, 1, 1, 16'h0007, 26'h0000000, 32'h0040_0040, 32'h0040_0044};
    vecs[11] = '{0, 0, 32'h1400_0008, 0, 0, 1, 1, 16'h0008, 26'h0000000, 32'h0040_0044, 32'h0040_0048};
    vecs[12] = '{0, 0, 32'h1000_8000, 0, 1, 0, 1, 16'h8000, 26'h0000000, 32'h0040_0048, 32'h003E_004C};
    vecs[13] = '{5, 3, 32'hFC00_0001, 0, 0, 0, 0, 16'h0000, 26'h0000000, 32'h003E_004C, 32'h003E_0050};

    rst_n = 1'b0; rst2_n = 1'b0;
    stall = 1'b0; jump = 1'b0; branch_eq = 1'b0; branch_ne = 1'b0; zero = 1'b0;
    imm = 16'h0; jump_target = 26'h0;
    imem.ready = 1'b0; imem.rdata = 32'h0;
    prev_instr = 32'h0;
    repeat (2) @(negedge clk);

    chk("rst_req", {31'h0, imem.req}, 32'd0);
    chk("rst_valid", {31'h0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_addr", imem.addr, 32'h0040_0000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_opcode", {26'h0, opcode}, 32'h0);
    chk("rst_err", {31'h0, fetch_err}, 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 14; k++) run_vec(vecs[k]);

    // Reset while waiting in REQ aborts the fetch.
    repeat (3) begin
      @(negedge clk);
      chk("wait_req", {31'h0, imem.req}, 32'd1);
      chk("wait_addr", imem.addr, 32'h003E_0050);
    end
    imem.ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req", {31'h0, imem.req}, 32'd0);
    chk("abort_valid", {31'h0, instr_valid}, 32'd0);
    chk("abort_pc", pc, 32'h0040_0000);
    chk("abort_instr", instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_req", {31'h0, imem.req}, 32'd1);
    chk("restart_addr", imem.addr, 32'h0040_0000);
    chk("restart_valid", {31'h0, instr_valid}, 32'd0);

    // Ready withheld: error after 15 REQ cycles when the timeout is built in.
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      chk("to_err", {31'h0, fetch_err}, {31'h0, TO_EN && (j >= 15)});
      chk("to_addr", imem.addr, 32'h0040_0000);
      chk("to_req", {31'h0, imem.req}, 32'd1);
    end
    imem.ready = 1'b1;
    imem.rdata = 32'h3C01_1234;
    @(negedge clk);
    imem.ready = 1'b0;
    chk("to_done_valid", {31'h0, instr_valid}, 32'd1);
    chk("to_done_instr", instr, 32'h3C01_1234);
    chk("to_done_pc", pc, 32'h0040_0000);
    chk("to_err_sticky", {31'h0, fetch_err}, {31'h0, TO_EN});
    rst_n = 1'b0;
    @(negedge clk);
    chk("to_err_cleared", {31'h0, fetch_err}, 32'd0);
    rst_n = 1'b1;

    // Wrap-around instance: ready tied high, one instruction every 2 cycles.
    rst2_n = 1'b1;
    @(negedge clk);
    chk("wrap_addr0", imem2.addr, 32'hFFFF_FFF8);
    chk("wrap_valid0", {31'h0, instr_valid2}, 32'd0);
    @(negedge clk);
    chk("wrap_valid1", {31'h0, instr_valid2}, 32'd1);
    chk("wrap_p4_1", pc_plus4_2, 32'hFFFF_FFFC);
    chk("wrap_instr", instr2, 32'h2400_0000);
    @(negedge clk);
    chk("wrap_addr1", imem2.addr, 32'hFFFF_FFFC);
    chk("wrap_valid2", {31'h0, instr_valid2}, 32'd0);
    @(negedge clk);
    chk("wrap_valid3", {31'h0, instr_valid2}, 32'd1);
    chk("wrap_p4_3", pc_plus4_2, 32'h0000_0000);
    @(negedge clk);
    chk("wrap_addr2", imem2.addr, 32'h0000_0000);
    chk("wrap_err", {31'h0, fetch_err2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
